// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the inst SRAM req/addr_ok/data_ok
// handshake with one request in flight, and buffers one instruction for decode.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } fs_state_t;

    fs_state_t   state;
    fs_state_t   state_next;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic [31:0] br_pc;
    logic [31:0] br_pc_next;
    logic        drop;
    logic        drop_next;
    logic [63:0] fs_bus;
    logic [63:0] fs_bus_next;

    logic        br_taken;
    logic [31:0] br_target;
    logic        br_low_unused;

    // Targets are always word aligned; the low two bits from decode carry no meaning.
    assign br_taken      = br_bus[32];
    assign br_target     = {br_bus[31:2], 2'b00};
    assign br_low_unused = ^br_bus[1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            br_pc    <= 32'h0;
            drop     <= 1'b0;
            fs_bus   <= 64'h0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            br_pc    <= br_pc_next;
            drop     <= drop_next;
            fs_bus   <= fs_bus_next;
        end
    end

    // A request already on the bus cannot be withdrawn, so a redirect during REQ/WAIT
    // only records the target and marks the in-flight word to be thrown away.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        br_pc_next    = br_pc;
        drop_next     = drop;
        fs_bus_next   = fs_bus;
        case (state)
            S_IDLE: begin
                state_next = S_REQ;
                if (br_taken) begin
                    fetch_pc_next = br_target;
                end
            end
            S_REQ: begin
                if (br_taken) begin
                    br_pc_next = br_target;
                    drop_next  = 1'b1;
                end
                if (inst_sram_addr_ok) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (br_taken) begin
                    br_pc_next = br_target;
                    drop_next  = 1'b1;
                end
                if (inst_sram_data_ok) begin
                    if (br_taken) begin
                        fetch_pc_next = br_target;
                        drop_next     = 1'b0;
                        state_next    = S_REQ;
                    end else if (drop) begin
                        fetch_pc_next = br_pc;
                        drop_next     = 1'b0;
                        state_next    = S_REQ;
                    end else begin
                        fs_bus_next = {inst_sram_rdata, fetch_pc};
                        state_next  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (br_taken) begin
                    fetch_pc_next = br_target;
                    state_next    = S_REQ;
                end else if (ds_allowin) begin
                    fetch_pc_next = fetch_pc + 32'd4;
                    state_next    = S_REQ;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign inst_sram_req   = (state == S_REQ);
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    assign fs_to_ds_valid  = (state == S_HOLD) & ~br_taken;
    assign fs_to_ds_bus    = fs_bus;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised and directed bench for if_fetch_stage; a transaction-level model feeds
// expected requests and instructions into queues that a negedge monitor checks.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    logic        clk;
    logic        resetn;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ds_allowin        (ds_allowin),
        .br_bus            (br_bus),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] reqQ[$];
    logic [63:0] itemQ[$];
    logic        expReqNow   = 1'b0;
    logic        expValidNow = 1'b0;
    logic        monOn       = 1'b0;

    // Reference model: program-order PC plus where the single fetch transaction stands.
    logic [31:0] mPc      = RESET_PC;
    logic [31:0] mReqPc   = RESET_PC;
    logic        mWant    = 1'b0;
    logic        mOut     = 1'b0;
    logic        mHold    = 1'b0;
    logic        mSquash  = 1'b0;
    logic        mReqLive = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus, with the model advanced by the same inputs.
    task automatic applyStimulus(input logic brTake, input logic [31:0] brTgt, input logic allow,
                                 input logic aok, input logic dok, input logic [31:0] rdat);
        logic nWant;
        logic nOut;
        logic nHold;
        @(posedge clk);
        #1;
        br_bus            = {brTake, brTgt};
        ds_allowin        = allow;
        inst_sram_addr_ok = aok;
        inst_sram_data_ok = dok;
        inst_sram_rdata   = rdat;
        if (mWant && !mReqLive) begin
            reqQ.push_back(mPc);
            mReqPc   = mPc;
            mReqLive = 1'b1;
            mSquash  = 1'b0;
        end
        expReqNow   = mWant;
        expValidNow = mHold && !brTake;
        nWant = mWant;
        nOut  = mOut;
        nHold = mHold;
        if (mWant && aok) begin
            nWant    = 1'b0;
            nOut     = 1'b1;
            mReqLive = 1'b0;
        end
        if (mOut && dok) begin
            nOut = 1'b0;
            if (mSquash || brTake) begin
                nWant = 1'b1;
            end else begin
                itemQ.push_back({rdat, mReqPc});
                nHold = 1'b1;
            end
        end
        if (mHold) begin
            if (brTake) begin
                if (itemQ.size() > 0) void'(itemQ.pop_front());
                nHold = 1'b0;
                nWant = 1'b1;
            end else if (allow) begin
                mPc   = mPc + 32'd4;
                nHold = 1'b0;
                nWant = 1'b1;
            end
        end
        if (brTake) begin
            mPc = brTgt & 32'hffff_fffc;
            if (mWant || mOut) mSquash = 1'b1;
        end
        mWant = nWant;
        mOut  = nOut;
        mHold = nHold;
    endtask

    task automatic resetDut(input logic staleDok);
        @(posedge clk);
        #1;
        resetn            = 1'b0;
        br_bus            = 33'h0;
        ds_allowin        = 1'b0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
        reqQ.delete();
        itemQ.delete();
        mPc = RESET_PC; mWant = 1'b0; mOut = 1'b0; mHold = 1'b0;
        mSquash = 1'b0; mReqLive = 1'b0;
        expReqNow = 1'b0; expValidNow = 1'b0;
        monOn = 1'b1;
        #1;
        checkOutput("reset req", {63'h0, inst_sram_req}, 64'h0);
        checkOutput("reset valid", {63'h0, fs_to_ds_valid}, 64'h0);
        checkOutput("reset addr", {32'h0, inst_sram_addr}, {32'h0, RESET_PC});
        checkOutput("reset bus", fs_to_ds_bus, 64'h0);
        checkOutput("const sram", {inst_sram_wdata, 25'h0, inst_sram_wr, inst_sram_size, inst_sram_wstrb},
                    {32'h0, 25'h0, 1'b0, 2'd2, 4'h0});
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        resetn            = 1'b1;
        inst_sram_data_ok = staleDok;
        inst_sram_rdata   = 32'hdead_beef;
        mWant             = 1'b1;
    endtask

    // Monitor: compares request level/address and presented instructions mid-cycle.
    always @(negedge clk) begin
        if (monOn) begin
            checkOutput("req level", {63'h0, inst_sram_req}, {63'h0, expReqNow});
            if (inst_sram_req) begin
                if (reqQ.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL req addr: got request %h expected none", inst_sram_addr);
                end else begin
                    checkOutput("req addr", {32'h0, inst_sram_addr}, {32'h0, reqQ[0]});
                    if (inst_sram_addr_ok) void'(reqQ.pop_front());
                end
            end
            checkOutput("valid level", {63'h0, fs_to_ds_valid}, {63'h0, expValidNow});
            if (fs_to_ds_valid) begin
                if (itemQ.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL fs bus: got %h expected no instruction", fs_to_ds_bus);
                end else begin
                    checkOutput("fs bus", fs_to_ds_bus, itemQ[0]);
                    if (ds_allowin) void'(itemQ.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        resetn            = 1'b0;
        br_bus            = 33'h0;
        ds_allowin        = 1'b0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;

        resetDut(1'b0);
        // Zero-wait SRAM, decode always ready: three back-to-back fetches.
        repeat (9) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, $urandom);
        // Decode stalls in HOLD, then accepts.
        for (int k = 0; k < 20 && !mHold; k++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, $urandom);
        repeat (5) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, $urandom);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, $urandom);
        // Slow addr_ok with a redirect in the first REQ cycle (unaligned target bits).
        applyStimulus(1'b1, 32'h1c00_0102, 1'b1, 1'b0, 1'b0, $urandom);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, $urandom);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, $urandom);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, $urandom);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, $urandom);
        // Redirect coinciding with data_ok.
        for (int k = 0; k < 20 && !mOut; k++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, $urandom);
        applyStimulus(1'b1, 32'h1c00_0200, 1'b1, 1'b0, 1'b1, $urandom);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, $urandom);
        // Redirect in HOLD while decode is ready.
        for (int k = 0; k < 20 && !mHold; k++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, $urandom);
        applyStimulus(1'b1, 32'h1c00_0300, 1'b1, 1'b1, 1'b1, $urandom);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, $urandom);
        // PC wrap past the top of the address space.
        for (int k = 0; k < 20 && !mHold; k++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, $urandom);
        applyStimulus(1'b1, 32'hffff_fffc, 1'b0, 1'b1, 1'b1, $urandom);
        repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, $urandom);
        // Same redirect held for several cycles while addr_ok is withheld.
        for (int k = 0; k < 20 && !mWant; k++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, $urandom);
        repeat (3) applyStimulus(1'b1, 32'h1c00_0400, 1'b1, 1'b0, 1'b0, $urandom);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, $urandom);
        // Reset while waiting for data; a stale data_ok follows the release.
        for (int k = 0; k < 20 && !mOut; k++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, $urandom);
        resetDut(1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, $urandom);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, $urandom);

        for (int i = 0; i < 3000; i++) begin
            tgt = RESET_PC + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
            if ($urandom_range(0, 40) == 0) tgt = 32'hffff_fffc;
            applyStimulus($urandom_range(0, 11) == 0, tgt, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom);
        end
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, $urandom);
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
